// File: rtl/burst_mem_responder_pkg.sv
// Shared types and constants for the 4-beat, 64-bit burst memory responder.
// Line size is 256 bits (32 bytes), so the low five address bits select nothing.
package burst_mem_responder_pkg;

  localparam int BURST_BEATS      = 4;
  localparam int BEAT_BITS        = 64;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEAT_IDX_BITS    = 2;
  localparam int LAT_BITS         = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } burst_state_t;

  typedef enum logic {
    READ,
    WRITE
  } burst_op_t;

endpackage

// File: rtl/burst_line_ram.sv
// Cacheline store: 2**LINE_IDX_BITS lines of four 64-bit beats.
// Combinational read port and synchronous write port; contents survive reset.
module burst_line_ram
  import burst_mem_responder_pkg::*;
#(
  parameter int LINE_IDX_BITS = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [LINE_IDX_BITS-1:0] wr_line,
  input  logic [BEAT_IDX_BITS-1:0] wr_beat,
  input  logic [BEAT_BITS-1:0]     wr_data,
  input  logic [LINE_IDX_BITS-1:0] rd_line,
  input  logic [BEAT_IDX_BITS-1:0] rd_beat,
  output logic [BEAT_BITS-1:0]     rd_data
);

  localparam int DEPTH = (2 ** LINE_IDX_BITS) * BURST_BEATS;

  logic [BEAT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_line, wr_beat}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_line, rd_beat}];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat burst interface with programmable latency.
// Also flags initiator protocol violations in a sticky protocol_err bit.
module burst_mem_responder
  import burst_mem_responder_pkg::*;
#(
  parameter int LINE_IDX_BITS = 8,
  parameter int LATENCY       = 10,
  parameter int BURST_LEN     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        mem_resp,
  output logic [63:0] mem_rdata,
  output logic        busy,
  output logic        protocol_err
);

  localparam logic [LAT_BITS-1:0]      LAT_INIT  = LAT_BITS'(LATENCY - 1);
  localparam logic [BEAT_IDX_BITS-1:0] LAST_BEAT = BEAT_IDX_BITS'(BURST_LEN - 1);

  burst_state_t               state;
  burst_state_t               next_state;
  burst_op_t                  op;
  logic [LINE_IDX_BITS-1:0]   line;
  logic [LAT_BITS-1:0]        lat_cnt;
  logic [BEAT_IDX_BITS-1:0]   beat;

  logic                       req_held;
  logic                       other_req;
  logic                       accept;
  logic                       both_req;
  logic                       violation;
  logic                       ram_we;
  logic [BEAT_BITS-1:0]       ram_rdata;

  // Offset bits and aliased upper bits deliberately do not select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[LINE_OFFSET_BITS-1:0],
                              mem_addr[31:LINE_OFFSET_BITS+LINE_IDX_BITS]};

  always_comb begin
    req_held  = (op == READ) ? mem_read  : mem_write;
    other_req = (op == READ) ? mem_write : mem_read;
    accept    = mem_read ^ mem_write;
    both_req  = mem_read & mem_write;
    violation = ((state == IDLE) && both_req) ||
                (((state == WAIT) || (state == BURST)) && (!req_held || other_req));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dropping the latched request in WAIT or BURST aborts straight back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          next_state = IDLE;
        end else if (lat_cnt == '0) begin
          next_state = BURST;
        end
      end
      BURST: begin
        if (!req_held) begin
          next_state = IDLE;
        end else if (beat == LAST_BEAT) begin
          next_state = DONE;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A write beat commits at the edge ending its resp cycle, unless rst lands on that edge.
  always_comb begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    busy      = (state != IDLE);
    ram_we    = 1'b0;
    if (state == BURST) begin
      mem_resp = 1'b1;
      if (op == READ) begin
        mem_rdata = ram_rdata;
      end else begin
        ram_we = mem_write & ~rst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= READ;
      line    <= '0;
      lat_cnt <= '0;
      beat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op      <= mem_write ? WRITE : READ;
            line    <= mem_addr[LINE_OFFSET_BITS +: LINE_IDX_BITS];
            lat_cnt <= LAT_INIT;
            beat    <= '0;
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_BITS'(1);
          end
        end
        BURST: begin
          if (beat != LAST_BEAT) begin
            beat <= beat + BEAT_IDX_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err <= 1'b0;
    end else if (violation) begin
      protocol_err <= 1'b1;
    end
  end

  burst_line_ram #(
    .LINE_IDX_BITS(LINE_IDX_BITS)
  ) u_line_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_line (line),
    .wr_beat (beat),
    .wr_data (mem_wdata),
    .rd_line (line),
    .rd_beat (beat),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: a cycle-indexed expectation timeline
// built from burst-level rules, checked every cycle, plus literal spot checks.
module tb_burst_mem_responder;

  localparam int L    = 10;
  localparam int MAXC = 1024;

  localparam logic [255:0] LINE2 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINE3 = {64'h3333_0000_0000_0603, 64'h2222_0000_0000_0602,
                                    64'h1111_0000_0000_0601, 64'h0000_0000_0000_0600};
  localparam logic [255:0] LINE4 = {64'h0808_0808_0808_0803, 64'h0808_0808_0808_0802,
                                    64'h0808_0808_0808_0801, 64'h0808_0808_0808_0800};
  localparam logic [255:0] LINE5 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                    64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
  localparam logic [255:0] LINE5_PARTIAL = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_resp;
  logic [63:0] mem_rdata;
  logic        busy;
  logic        protocol_err;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs per cycle; cycle c is the interval after the c-th rising edge.
  bit          exp_valid [MAXC];
  logic        exp_resp  [MAXC];
  logic [63:0] exp_rdata [MAXC];
  logic        exp_busy  [MAXC];
  logic        exp_err   [MAXC];

  logic [63:0] model_mem [256][4];
  logic        model_err;

  burst_mem_responder #(
    .LINE_IDX_BITS(8),
    .LATENCY      (L),
    .BURST_LEN    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare process: checks every cycle for which an expectation was recorded.
  always @(negedge clk) begin
    if (cyc < MAXC && exp_valid[cyc]) begin
      checkOutput($sformatf("mem_resp@%0d", cyc), 256'(mem_resp), 256'(exp_resp[cyc]));
      checkOutput($sformatf("mem_rdata@%0d", cyc), 256'(mem_rdata), 256'(exp_rdata[cyc]));
      checkOutput($sformatf("busy@%0d", cyc), 256'(busy), 256'(exp_busy[cyc]));
      checkOutput($sformatf("protocol_err@%0d", cyc), 256'(protocol_err), 256'(exp_err[cyc]));
    end
  end

  task automatic applyStimulus(input logic r, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [63:0] wd);
    @(posedge clk);
    #1;
    rst       = r;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = wd;
  endtask

  task automatic expectCycle(input logic resp, input logic [63:0] rdata, input logic bsy);
    if (cyc < MAXC) begin
      exp_valid[cyc] = 1'b1;
      exp_resp[cyc]  = resp;
      exp_rdata[cyc] = rdata;
      exp_busy[cyc]  = bsy;
      exp_err[cyc]   = model_err;
    end
  endtask

  function automatic int lineOf(input logic [31:0] a);
    return int'((a >> 5) & 32'h0000_00FF);
  endfunction

  // One full burst: request in an idle cycle, L wait cycles, 4 beats, one DONE cycle.
  task automatic doBurst(input bit is_write, input logic [31:0] addr, input logic [255:0] wline,
                         input bit hold, input logic [31:0] next_addr, input bit poke_other,
                         output int lat, output int nresp, output logic [255:0] rline);
    int   ln;
    int   first;
    int   accept_edge;
    logic rd;
    logic wr;
    ln    = lineOf(addr);
    rd    = !is_write;
    wr    = is_write;
    first = -1;
    nresp = 0;
    rline = '0;
    applyStimulus(1'b0, rd, wr, addr, 64'h0);
    expectCycle(1'b0, 64'h0, 1'b0);
    accept_edge = cyc + 1;
    for (int k = 1; k <= L; k++) begin
      applyStimulus(1'b0, rd | (poke_other & wr & (k == 3)), wr | (poke_other & rd & (k == 3)),
                    ~addr, 64'h0);
      expectCycle(1'b0, 64'h0, 1'b1);
      if (poke_other && k == 3) model_err = 1'b1;
      #1;
      if (mem_resp) begin
        nresp++;
        if (first < 0) first = cyc;
      end
    end
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, rd, wr, ~addr, wline[b*64 +: 64]);
      expectCycle(1'b1, is_write ? 64'h0 : model_mem[ln][b], 1'b1);
      #1;
      if (mem_resp) begin
        nresp++;
        if (first < 0) first = cyc;
      end
      rline[b*64 +: 64] = mem_rdata;
      if (is_write) model_mem[ln][b] = wline[b*64 +: 64];
    end
    applyStimulus(1'b0, hold & rd, hold & wr, next_addr, 64'h0);
    expectCycle(1'b0, 64'h0, 1'b1);
    #1;
    if (mem_resp) nresp++;
    lat = (first < 0) ? -1 : first - accept_edge;
  endtask

  task automatic doReset(input int n);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    model_err = 1'b0;
    for (int i = 1; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
      expectCycle(1'b0, 64'h0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    expectCycle(1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    int             lat;
    int             nr;
    logic [255:0]   got;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 64'h0;
    model_err = 1'b0;

    doReset(3);
    checkOutput("reset_mem_resp", 256'(mem_resp), 256'(0));
    checkOutput("reset_mem_rdata", 256'(mem_rdata), 256'(0));
    checkOutput("reset_busy", 256'(busy), 256'(0));
    checkOutput("reset_protocol_err", 256'(protocol_err), 256'(0));

    // Fill lines 2, 3 and 4 with distinct patterns.
    doBurst(1'b1, 32'h0000_0040, LINE2, 1'b0, 32'h0, 1'b0, lat, nr, got);
    doBurst(1'b1, 32'h0000_0060, LINE3, 1'b0, 32'h0, 1'b0, lat, nr, got);
    doBurst(1'b1, 32'h0000_0080, LINE4, 1'b0, 32'h0, 1'b0, lat, nr, got);

    doBurst(1'b0, 32'h0000_0040, '0, 1'b0, 32'h0, 1'b0, lat, nr, got);
    checkOutput("wr_rd_beat0", 256'(got[63:0]), 256'(64'h1111_1111_1111_1111));
    checkOutput("wr_rd_beat1", 256'(got[127:64]), 256'(64'h2222_2222_2222_2222));
    checkOutput("wr_rd_beat2", 256'(got[191:128]), 256'(64'h3333_3333_3333_3333));
    checkOutput("wr_rd_beat3", 256'(got[255:192]), 256'(64'h4444_4444_4444_4444));
    checkOutput("read_latency", 256'(lat), 256'(10));
    checkOutput("read_resp_count", 256'(nr), 256'(4));
    checkOutput("wr_rd_protocol_err", 256'(protocol_err), 256'(0));

    // 0x0001_007F aliases onto line 3.
    doBurst(1'b0, 32'h0001_007F, '0, 1'b0, 32'h0, 1'b0, lat, nr, got);
    checkOutput("alias_line", got, LINE3);

    // Request held through DONE with the address moved to 0x80.
    doBurst(1'b0, 32'h0000_0040, '0, 1'b1, 32'h0000_0080, 1'b0, lat, nr, got);
    checkOutput("b2b_first_line", got, LINE2);
    doBurst(1'b0, 32'h0000_0080, '0, 1'b0, 32'h0, 1'b0, lat, nr, got);
    checkOutput("b2b_second_line", got, LINE4);
    checkOutput("b2b_second_latency", 256'(lat), 256'(10));

    // Write raised mid-read: error flagged but the read completes.
    doBurst(1'b0, 32'h0000_0040, '0, 1'b0, 32'h0, 1'b1, lat, nr, got);
    checkOutput("other_op_line", got, LINE2);
    checkOutput("other_op_count", 256'(nr), 256'(4));
    checkOutput("other_op_protocol_err", 256'(protocol_err), 256'(1));

    // Read and write both high while idle.
    doReset(2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040, 64'h0);
      expectCycle(1'b0, 64'h0, 1'b0);
      model_err = 1'b1;
    end
    for (int k = 0; k < L + 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0040, 64'h0);
      expectCycle(1'b0, 64'h0, 1'b0);
    end
    checkOutput("both_high_protocol_err", 256'(protocol_err), 256'(1));
    checkOutput("both_high_mem_resp", 256'(mem_resp), 256'(0));

    // Read dropped during WAIT.
    doReset(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0040, 64'h0);
    expectCycle(1'b0, 64'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0040, 64'h0);
      expectCycle(1'b0, 64'h0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0040, 64'h0);
    expectCycle(1'b0, 64'h0, 1'b1);
    model_err = 1'b1;
    for (int k = 0; k < L + 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0040, 64'h0);
      expectCycle(1'b0, 64'h0, 1'b0);
      if (k == 0) checkOutput("drop_wait_busy", 256'(busy), 256'(0));
    end
    checkOutput("drop_wait_protocol_err", 256'(protocol_err), 256'(1));

    // Reset lands during beat 2 of a write: beats 0 and 1 stay committed.
    doReset(2);
    doBurst(1'b1, 32'h0000_00A0, LINE5, 1'b0, 32'h0, 1'b0, lat, nr, got);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_00A0, 64'h0);
    expectCycle(1'b0, 64'h0, 1'b0);
    for (int k = 1; k <= L; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_00A0, 64'h0);
      expectCycle(1'b0, 64'h0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_00A0, 64'hAAAA_AAAA_AAAA_AAAA);
    expectCycle(1'b1, 64'h0, 1'b1);
    model_mem[5][0] = 64'hAAAA_AAAA_AAAA_AAAA;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_00A0, 64'hBBBB_BBBB_BBBB_BBBB);
    expectCycle(1'b1, 64'h0, 1'b1);
    model_mem[5][1] = 64'hBBBB_BBBB_BBBB_BBBB;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_00A0, 64'hCCCC_CCCC_CCCC_CCCC);
    expectCycle(1'b1, 64'h0, 1'b1);
    model_err = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    expectCycle(1'b0, 64'h0, 1'b0);
    checkOutput("reset_mid_write_resp", 256'(mem_resp), 256'(0));
    doBurst(1'b0, 32'h0000_00A0, '0, 1'b0, 32'h0, 1'b0, lat, nr, got);
    checkOutput("partial_write_line", got, LINE5_PARTIAL);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    expectCycle(1'b0, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
